// File: rtl/adder_seq_pkg.sv
// Shared definitions for the multicycle adder sequencer family:
// FSM encoding and the chunk-width configuration check.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // True when a W-bit word splits into whole chunks of a nonzero width not exceeding W.
    function automatic bit width_cfg_ok(input int unsigned w, input int unsigned chunk);
        return (chunk != 0) && (chunk <= w) && ((w % chunk) == 0);
    endfunction

endpackage

// File: rtl/multicycle_adder_sequencer.sv
// Sequences a W-bit add through an external CHUNK-bit adder core, LSB chunk first,
// carrying the core's carry-out between cycles through carry_q.
module multicycle_adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic             out_cout,
    output logic [CHUNK-1:0] add_a,
    output logic [CHUNK-1:0] add_b,
    output logic             add_cin,
    input  logic [CHUNK-1:0] add_y,
    input  logic             add_cout
);

    localparam int unsigned NCHUNK = W / CHUNK;
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (!width_cfg_ok(W, CHUNK)) begin : g_bad_cfg
        $error("multicycle_adder_sequencer: W must be a nonzero multiple of CHUNK");
    end

    seq_state_e        state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      y_q, y_d;
    logic              carry_q, carry_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CHUNK-1:0]  add_a_q, add_a_d;
    logic [CHUNK-1:0]  add_b_q, add_b_d;
    logic              add_cin_q, add_cin_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
        carry_d  = carry_q;
        idx_d    = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                y_d[32'(idx_q) * CHUNK +: CHUNK] = add_y;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Core ports are registered from next state so they are valid the whole RUN cycle.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        add_a_d     = '0;
        add_b_d     = '0;
        add_cin_d   = 1'b0;
        if (state_d == ST_RUN) begin
            add_a_d   = a_d[32'(idx_d) * CHUNK +: CHUNK];
            add_b_d   = b_d[32'(idx_d) * CHUNK +: CHUNK];
            add_cin_d = carry_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = y_q;
    assign out_cout  = carry_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_multicycle_adder_sequencer.sv
// Bench for multicycle_adder_sequencer: 64/16 instance with a scoreboard of
// expected sums, plus a single-chunk 16/16 instance.
module tb_multicycle_adder_sequencer;

    localparam int unsigned W      = 64;
    localparam int unsigned CHUNK  = 16;
    localparam int unsigned NCHUNK = W / CHUNK;
    localparam int unsigned SW     = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_y;
    logic             out_cout;
    logic [CHUNK-1:0] add_a, add_b, core_y;
    logic             add_cin, core_cout;

    logic          s_in_valid = 1'b0;
    logic          s_in_ready;
    logic [SW-1:0] s_in_a = '0;
    logic [SW-1:0] s_in_b = '0;
    logic          s_out_valid;
    logic          s_out_ready = 1'b0;
    logic [SW-1:0] s_out_y;
    logic          s_out_cout;
    logic [SW-1:0] s_add_a, s_add_b, s_core_y;
    logic          s_add_cin, s_core_cout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder cores.
    assign {core_cout, core_y}     = 17'(add_a) + 17'(add_b) + 17'(add_cin);
    assign {s_core_cout, s_core_y} = 17'(s_add_a) + 17'(s_add_b) + 17'(s_add_cin);

    multicycle_adder_sequencer #(.W(W), .CHUNK(CHUNK)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_cout(out_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_y(core_y), .add_cout(core_cout)
    );

    multicycle_adder_sequencer #(.W(SW), .CHUNK(SW)) u_dut_single (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_cin(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_y(s_out_y), .out_cout(s_out_cout),
        .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
        .add_y(s_core_y), .add_cout(s_core_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand transfer; returns at accept edge + 1 and queues the expected sum.
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           output int acc_cyc);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        sb.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(cin));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, out_valid, out_cout, add_cin} !== 4'b1000 || out_y !== '0 ||
            add_a !== '0 || add_b !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b y=%h cout=%b add_a=%h add_b=%h cin=%b required 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_y, out_cout, add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry_ripple();
        int t0, n;
        logic [W:0] exp;
        send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, t0);
        wait_valid(n);
        checks++;
        if (out_valid !== 1'b1 || n != int'(NCHUNK)) begin
            errors++;
            $display("FAIL ripple_latency: valid=%b after %0d edges required 1 after %0d", out_valid, n, NCHUNK);
        end
        exp = sb.pop_front();
        checks++;
        if ({out_cout, out_y} !== exp || exp !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL ripple_sum: got %b_%h required %b_%h", out_cout, out_y, exp[W], exp[W-1:0]);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ripple_drop: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_in_chain();
        int t0, n;
        logic [W:0] exp;
        send_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, t0);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_cout, out_y} !== exp || exp !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL cin_chain: vld=%b got %b_%h required 1 %b_%h", out_valid, out_cout, out_y, exp[W], exp[W-1:0]);
        end
        handshake();
    endtask

    task automatic test_core_trace();
        int t0;
        logic [W:0] exp;
        logic [CHUNK-1:0] ea[4];
        logic [CHUNK-1:0] eb[4];
        logic             ec[4];
        ea = '{16'hFFFF, 16'h0, 16'h0, 16'h0};
        eb = '{16'h0001, 16'h0, 16'h0, 16'h0};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL trace_idle: add_a=%h add_b=%h cin=%b required 0 0 0", add_a, add_b, add_cin);
        end
        send_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, t0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (add_a !== ea[i] || add_b !== eb[i] || add_cin !== ec[i]) begin
                errors++;
                $display("FAIL trace_run%0d: add_a=%h add_b=%h cin=%b required %h %h %b",
                         i, add_a, add_b, add_cin, ea[i], eb[i], ec[i]);
            end
            tick();
        end
        exp = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0 ||
            {out_cout, out_y} !== exp) begin
            errors++;
            $display("FAIL trace_done: vld=%b add_a=%h add_b=%h cin=%b y=%h required 1 0 0 0 %h",
                     out_valid, add_a, add_b, add_cin, out_y, exp[W-1:0]);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int t0, n;
        logic [W:0] exp;
        logic [W-1:0] y0;
        logic c0;
        send_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, t0);
        wait_valid(n);
        y0 = out_y;
        c0 = out_cout;
        in_valid = 1'b1;
        in_a     = 64'hAAAA_AAAA_AAAA_AAAA;
        in_b     = 64'h5555_5555_5555_5555;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_y !== y0 || out_cout !== c0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b y=%h cout=%b required 1 0 %h %b",
                         i, out_valid, in_ready, out_y, out_cout, y0, c0);
            end
        end
        in_valid = 1'b0;
        exp = sb.pop_front();
        checks++;
        if ({out_cout, out_y} !== exp) begin
            errors++;
            $display("FAIL bp_sum: got %b_%h required %b_%h", out_cout, out_y, exp[W], exp[W-1:0]);
        end
        handshake();
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_a !== '0) begin
            errors++;
            $display("FAIL bp_idle: vld=%b rdy=%b add_a=%h required 0 1 0", out_valid, in_ready, add_a);
        end
    endtask

    task automatic test_back_to_back();
        int t[3];
        int n;
        logic [W:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), t[i]);
            wait_valid(n);
            exp = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_cout, out_y} !== exp) begin
                errors++;
                $display("FAIL b2b_sum%0d: vld=%b got %b_%h required 1 %b_%h",
                         i, out_valid, out_cout, out_y, exp[W], exp[W-1:0]);
            end
            tick();
            if (i > 0) begin
                checks++;
                if (t[i] - t[i-1] != int'(NCHUNK) + 2) begin
                    errors++;
                    $display("FAIL b2b_period%0d: %0d cycles required %0d", i, t[i] - t[i-1], NCHUNK + 2);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int t0, n;
        logic [W:0] exp;
        send_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, t0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++;
        if ({in_ready, out_valid, out_cout, add_cin} !== 4'b1000 || out_y !== '0 ||
            add_a !== '0 || add_b !== '0) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b vld=%b y=%h cout=%b add_a=%h cin=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, out_y, out_cout, add_a, add_cin);
        end
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_out: vld=%b required 0", out_valid);
        end
        send_op(64'd5, 64'd7, 1'b0, t0);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_cout, out_y} !== exp || exp !== 65'd12) begin
            errors++;
            $display("FAIL midrun_after: vld=%b got %b_%h required 1 0_%h", out_valid, out_cout, out_y, 64'd12);
        end
        handshake();
    endtask

    task automatic test_single_chunk();
        s_in_valid = 1'b1;
        s_in_a     = 16'h8000;
        s_in_b     = 16'h8000;
        tick();
        s_in_valid = 1'b0;
        checks++;
        if (s_add_a !== 16'h8000 || s_add_b !== 16'h8000 || s_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_run: add_a=%h add_b=%h vld=%b required 8000 8000 0", s_add_a, s_add_b, s_out_valid);
        end
        tick();
        checks++;
        if (s_out_valid !== 1'b1 || s_out_y !== 16'h0 || s_out_cout !== 1'b1 || s_add_a !== '0) begin
            errors++;
            $display("FAIL single_done: vld=%b y=%h cout=%b add_a=%h required 1 0000 1 0000",
                     s_out_valid, s_out_y, s_out_cout, s_add_a);
        end
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_drop: vld=%b rdy=%b required 0 1", s_out_valid, s_in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_carry_ripple();
        test_carry_in_chain();
        test_core_trace();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_single_chunk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_adder_sequencer.md
# multicycle_adder_sequencer

Sequences a wide W-bit addition through one shared CHUNK-bit combinational adder core, LSB chunk first, over W/CHUNK cycles. Each cycle's carry-out is registered and used as the next cycle's carry-in. Operand and result transfer use valid/ready handshakes. The adder core sits outside the block and is driven through a dedicated port group, so any CHUNK-wide carry-propagation or conditional-sum adder in the codebase can be attached.

## Interface
- W, 64, total operand width
- CHUNK, 16, width of the attached adder core; W % CHUNK == 0 is required
- NCHUNK, W/CHUNK, derived chunk count; not overridden
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- in_a, in_b  input  W  operands
- in_cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_y  output  W  sum
- out_cout  output  1  final carry-out
- add_a, add_b  output  CHUNK  operand chunk to the adder core
- add_cin  output  1  carry-in to the adder core
- add_y  input  CHUNK  adder core sum, combinational from add_*
- add_cout  input  1  adder core carry-out

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_a, in_b into operand registers. Load carry_q<=in_cin and idx<=0. Go to RUN.
- RUN:
  - add_a=a_q[idx*CHUNK +: CHUNK], add_b likewise, add_cin=carry_q.
  - Each edge: y_q[idx chunk]<=add_y, carry_q<=add_cout, idx<=idx+1.
  - At idx==NCHUNK-1, go to DONE instead of incrementing.
- DONE:
  - out_valid=1, out_y=y_q, out_cout=carry_q.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. No operation overlap.
- add_a, add_b, add_cin are 0 outside RUN.
- idx width is max(1,$clog2(NCHUNK)).
- NCHUNK==1 is legal: RUN lasts exactly one cycle.
- Elaboration must fail if W % CHUNK != 0 or CHUNK > W.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_y=0, out_cout=0, add_a=add_b=0, add_cin=0. carry_q, idx and the operand registers clear to 0.
- Reset mid-operation aborts immediately. The partial result is discarded and no out handshake occurs.
- Latency: if operands are accepted at edge E0, then out_valid rises after edge E_NCHUNK, which is exactly NCHUNK edges later.
- Output stability: out_y and out_cout hold stable while out_valid=1 and out_ready=0.
- Drop: out_valid falls on the edge after out_valid&out_ready.
- in_ready rises in the cycle after the out handshake.
- Throughput: one operation per NCHUNK+2 cycles with out_ready held high.
- The combinational path add_* → core → add_y/add_cout must close within one clk period. This block adds no register on that path.

## Structure
- Shared package adder_seq_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the width-check helper used by all sequencer/combine blocks
- No sub-module inside this block.
- The natural companion is the CHUNK-wide adder core, instantiated by the parent and wired to add_*.
- The testbench instantiates a behavioural CHUNK-bit adder as the core.

## Test plan
All scenarios use W=64, CHUNK=16 unless stated.
- Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → y=0, cout=1. out_valid rises exactly 4 edges after the accept edge.
- Carry-in chain: a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, cin=1 → y=0, cout=1.
- Core port trace: a=64'h0000_0000_0000_FFFF, b=1, cin=0. The four RUN cycles must show:
  - add_a = FFFF, 0, 0, 0
  - add_cin = 0, 1, 0, 0
  - all add_* = 0 in IDLE/DONE
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → out_y/out_cout stable, in_ready=0, new operands not captured. Release → handshake, then IDLE.
- Reset mid-RUN: assert rst_n=0 after 2 RUN edges → all outputs at reset values asynchronously, no out handshake. Then run a=5, b=7, cin=0 → y=12, cout=0.
- Degenerate/illegal params:
  - W=16, CHUNK=16, a=16'h8000, b=16'h8000 → y=0, cout=1 after 1 edge.
  - W=48, CHUNK=32 → elaboration fails.
